sequenciador_pc: RTL

- Program-counter sequencer for the single-cycle LabSO core.
- Consumes the branch-taken flag from the comparison unit, plus jump, syscall, halt and input-wait controls from the control unit.
- Produces the next instruction address.
- Owns the halt / wait-for-input FSM, the confirm-button synchronizer and the OS context-return register (pc_salvo).

---
 rtl/pkg_labso.sv | 13 +
 rtl/sincroniza_borda.sv | 26 ++
 rtl/sequenciador_pc.sv | 120 ++++++++++++
 3 files changed

// File: rtl/pkg_labso.sv
// Shared definitions for the LabSO core: FSM state encoding and default address constants.
package pkg_labso;

    localparam int unsigned LARGURA_PC_PADRAO = 32;
    localparam int unsigned VETOR_SO_PADRAO   = 0;

    typedef enum logic [1:0] {
        EXECUTA = 2'd0,
        HALT    = 2'd1,
        ESPERA  = 2'd2
    } estado_t;

endpackage

// File: rtl/sincroniza_borda.sv
// Two-flop synchronizer for an asynchronous button followed by a registered rising-edge pulse.
module sincroniza_borda (
    input  logic clock,
    input  logic reset,
    input  logic entrada,
    output logic pulso
);

    logic sinc1, sinc2, anterior;

    always_ff @(posedge clock) begin
        if (reset) begin
            sinc1    <= 1'b0;
            sinc2    <= 1'b0;
            anterior <= 1'b0;
            pulso    <= 1'b0;
        end else begin
            sinc1    <= entrada;
            sinc2    <= sinc1;
            anterior <= sinc2;
            // One pulse per press, however long the button is held.
            pulso    <= sinc2 & ~anterior;
        end
    end

endmodule

// File: rtl/sequenciador_pc.sv
// Program-counter sequencer: next-pc selection, HALT / input-wait FSM and OS return register.
module sequenciador_pc
    import pkg_labso::*;
#(
    parameter int unsigned LARGURA_PC = LARGURA_PC_PADRAO,
    parameter int unsigned PC_RESET   = 0,
    parameter int unsigned VETOR_SO   = VETOR_SO_PADRAO
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  resultado_comparacao,
    input  logic                  eh_branch,
    input  logic                  eh_jump,
    input  logic                  eh_jr,
    input  logic                  eh_syscall,
    input  logic                  eh_retorno,
    input  logic                  eh_halt,
    input  logic                  eh_entrada,
    input  logic                  stall,
    input  logic                  retomar,
    input  logic                  botao_confirma,
    input  logic [15:0]           imediato,
    input  logic [25:0]           endereco_jump,
    input  logic [LARGURA_PC-1:0] valor_registrador,
    output logic [LARGURA_PC-1:0] pc,
    output logic [LARGURA_PC-1:0] pc_mais_um,
    output logic [LARGURA_PC-1:0] pc_salvo,
    output logic                  habilita_execucao,
    output logic                  parado,
    output logic                  esperando_entrada
);

    localparam logic [LARGURA_PC-1:0] PC_INICIAL = LARGURA_PC'(PC_RESET);
    localparam logic [LARGURA_PC-1:0] ENDERECO_SO = LARGURA_PC'(VETOR_SO);

    estado_t               estado, estado_prox;
    logic [LARGURA_PC-1:0] pc_prox, salvo_prox;
    logic [LARGURA_PC-1:0] alvo_branch, alvo_jump;
    logic                  confirma_pulso;

    sincroniza_borda u_sincroniza_borda (
        .clock   (clock),
        .reset   (reset),
        .entrada (botao_confirma),
        .pulso   (confirma_pulso)
    );

    assign pc_mais_um  = pc + 1'b1;
    assign alvo_branch = pc_mais_um + {{(LARGURA_PC-16){imediato[15]}}, imediato};
    assign alvo_jump   = {pc[LARGURA_PC-1:26], endereco_jump};

    always_comb begin
        pc_prox           = pc;
        salvo_prox        = pc_salvo;
        estado_prox       = estado;
        habilita_execucao = 1'b0;
        case (estado)
            EXECUTA: begin
                habilita_execucao = !stall;
                if (!stall) begin
                    if (eh_halt) begin
                        estado_prox = HALT;
                    end else if (eh_entrada) begin
                        if (confirma_pulso) begin
                            pc_prox = pc_mais_um;
                        end else begin
                            estado_prox       = ESPERA;
                            habilita_execucao = 1'b0;
                        end
                    end else if (eh_syscall) begin
                        salvo_prox = pc_mais_um;
                        pc_prox    = ENDERECO_SO;
                    end else if (eh_retorno) begin
                        pc_prox = pc_salvo;
                    end else if (eh_jr) begin
                        pc_prox = valor_registrador;
                    end else if (eh_jump) begin
                        pc_prox = alvo_jump;
                    end else if (eh_branch && resultado_comparacao) begin
                        pc_prox = alvo_branch;
                    end else begin
                        pc_prox = pc_mais_um;
                    end
                end
            end
            HALT: begin
                // Step over the halt instruction exactly once when resumed.
                if (retomar) begin
                    pc_prox     = pc_mais_um;
                    estado_prox = EXECUTA;
                end
            end
            ESPERA: begin
                if (confirma_pulso) begin
                    habilita_execucao = 1'b1;
                    pc_prox           = pc_mais_um;
                    estado_prox       = EXECUTA;
                end
            end
            default: estado_prox = EXECUTA;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            estado            <= EXECUTA;
            pc                <= PC_INICIAL;
            pc_salvo          <= '0;
            parado            <= 1'b0;
            esperando_entrada <= 1'b0;
        end else begin
            estado            <= estado_prox;
            pc                <= pc_prox;
            pc_salvo          <= salvo_prox;
            parado            <= (estado_prox == HALT);
            esperando_entrada <= (estado_prox == ESPERA);
        end
    end

endmodule
